// File: rtl/posit_encode_pkg.sv
// Shared posit encoder types and constants for the default 8-bit, es=1 configuration.
package posit_encode_pkg;

  localparam int POSIT_W   = 8;
  localparam int POSIT_ES  = 1;
  localparam int POSIT_REG = $clog2(POSIT_W) + 1;
  localparam int POSIT_MAN = POSIT_W;

  typedef struct packed {
    logic                        sign;
    logic signed [POSIT_REG-1:0] regime;
    logic [POSIT_ES-1:0]         exponent;
    logic [POSIT_MAN-1:0]        mantissa;
    logic                        zero;
    logic                        nar;
  } posit_fields_t;

  localparam logic [POSIT_W-1:0] MAXPOS      = {1'b0, {(POSIT_W-1){1'b1}}};
  localparam logic [POSIT_W-1:0] MINPOS      = {{(POSIT_W-1){1'b0}}, 1'b1};
  localparam logic [POSIT_W-1:0] NAR_PATTERN = {1'b1, {(POSIT_W-1){1'b0}}};

endpackage

// File: rtl/posit_round.sv
// Final posit assembly: round the body, clamp to maxpos/minpos, apply sign, mux specials.
// FRIC_ENCODE_RNE_EN selects round-to-nearest-even; otherwise the body is truncated.
module posit_round #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0] body,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  logic             sat_max,
  input  logic             sat_min,
  input  logic             zero,
  input  logic             nar,
  output logic [WIDTH-1:0] posit
);
  localparam int B = WIDTH - 1;

  logic         inc;
  logic [B:0]   sum;
  logic [B-1:0] mag;

`ifdef FRIC_ENCODE_RNE_EN
  assign inc = guard & (sticky | body[0]);
`else
  logic unused_rnd;
  assign unused_rnd = guard ^ sticky;
  assign inc        = 1'b0;
`endif

  always_comb begin
    // carry from the increment ripples through exponent and regime in the packed body
    sum = {1'b0, body} + {{B{1'b0}}, inc};
    mag = sum[B-1:0];
    if (sat_max)              mag = '1;
    else if (sat_min)         mag = {{(B-1){1'b0}}, 1'b1};
    else if (sum[B])          mag = '1;
    else if (mag == '0)       mag = {{(B-1){1'b0}}, 1'b1};
    posit = sign ? -{1'b0, mag} : {1'b0, mag};
    if (zero) posit = '0;
    if (nar)  posit = {1'b1, {B{1'b0}}};
  end

endmodule

// File: rtl/posit_encode.sv
// Two-stage posit encoder: stage 1 packs regime/exponent/mantissa, stage 2 rounds and signs.
// Rounding mode is selected by FRIC_ENCODE_RNE_EN (see posit_round).
module posit_encode
  import posit_encode_pkg::*;
#(
  parameter int WIDTH = POSIT_W,
  parameter int EN    = POSIT_ES,
  parameter int W_REG = $clog2(WIDTH) + 1,
  parameter int W_MAN = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [W_REG-1:0] in_regime,
  input  logic [EN-1:0]    in_exponent,
  input  logic [W_MAN-1:0] in_mantissa,
  input  logic             in_zero,
  input  logic             in_nar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_posit
);
  localparam int STAGES = 2;
  localparam int XW     = 2 + EN + W_MAN + WIDTH;

  typedef struct packed {
    logic [WIDTH-2:0] body;
    logic             guard;
    logic             sticky;
    logic             sign;
    logic             sat_max;
    logic             sat_min;
    logic             zero;
    logic             nar;
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  logic             s2_load;
  logic             k_neg;
  logic [W_REG-1:0] run;
  logic [XW-1:0]    seed;
  logic [XW-1:0]    shifted;
  s1_t              s1_next;
  s1_t              s1_q;
  logic [WIDTH-1:0] round_posit;

  assign s2_load   = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_load;
  assign out_valid = vld_pipe[2];

  // Seed "10"/"01" then sign-extend right by the run length: k>=0 gives k+1 ones
  // then 0, k<0 gives -k zeros then 1. The zero pad keeps every shifted bit for sticky.
  always_comb begin
    k_neg   = in_regime[W_REG-1];
    run     = k_neg ? ~in_regime : in_regime;
    seed    = {(k_neg ? 2'b01 : 2'b10), in_exponent, in_mantissa, {WIDTH{1'b0}}};
    shifted = $signed(seed) >>> run;
    s1_next         = '0;
    s1_next.body    = shifted[XW-1 -: WIDTH-1];
    s1_next.guard   = shifted[XW-WIDTH];
    s1_next.sticky  = |shifted[XW-WIDTH-1:0];
    s1_next.sign    = in_sign;
    s1_next.sat_max = !k_neg && (run > W_REG'(WIDTH-2));
    s1_next.sat_min = k_neg && (run > W_REG'(WIDTH-2));
    s1_next.zero    = in_zero;
    s1_next.nar     = in_nar;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      out_posit <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) out_posit <= round_posit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) s1_q <= s1_next;
  end

  posit_round #(.WIDTH(WIDTH)) u_round (
    .body    (s1_q.body),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .sign    (s1_q.sign),
    .sat_max (s1_q.sat_max),
    .sat_min (s1_q.sat_min),
    .zero    (s1_q.zero),
    .nar     (s1_q.nar),
    .posit   (round_posit)
  );

endmodule

// File: tb/tb_posit_encode.sv
// Scoreboard bench for posit_encode: directed fields in, expected posits queued, monitor compares.
module tb_posit_encode;
  localparam int WIDTH = 8;
  localparam int EN    = 1;
  localparam int W_REG = 4;
  localparam int W_MAN = 8;

`ifdef FRIC_ENCODE_RNE_EN
  localparam logic [7:0] EXP_18  = 8'h42;
  localparam logic [7:0] EXP_OVF = 8'h7F;
`else
  localparam logic [7:0] EXP_18  = 8'h41;
  localparam logic [7:0] EXP_OVF = 8'h7E;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [W_REG-1:0] in_regime = '0;
  logic [EN-1:0]    in_exponent = '0;
  logic [W_MAN-1:0] in_mantissa = '0;
  logic             in_zero = 1'b0;
  logic             in_nar = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_posit;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       held_v = 1'b0;
  logic [7:0] held = '0;

  always #5 clk = ~clk;

  posit_encode #(.WIDTH(WIDTH), .EN(EN), .W_REG(W_REG), .W_MAN(W_MAN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_regime   (in_regime),
    .in_exponent (in_exponent),
    .in_mantissa (in_mantissa),
    .in_zero     (in_zero),
    .in_nar      (in_nar),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, expv);
    end
  endtask

  // Monitor: mid-cycle sample; a word is consumed when out_valid && out_ready.
  initial forever begin
    @(negedge clk);
    if (!rst_n) held_v = 1'b0;
    else begin
      if (out_valid && held_v) chk("hold", out_posit, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %h want none", out_posit);
        end else chk("out", out_posit, exp_q.pop_front());
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = out_posit;
      end else held_v = 1'b0;
    end
  end

  task automatic send(input logic s, input logic [3:0] k, input logic e, input logic [7:0] m,
                      input logic z, input logic n, input logic [7:0] expv, input bit push);
    int t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = s; in_regime = k; in_exponent = e;
    in_mantissa = m; in_zero = z; in_nar = n;
    #1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 want 1");
    end else if (push) exp_q.push_back(expv);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    int n;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    n = exp_q.size();
    chk("drain_left", 8'(n), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_posit", out_posit, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);

    // unit value with latency check
    send(1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("lat_cycle1", {7'b0, out_valid}, 8'h00);
    @(posedge clk); #2;
    chk("lat_cycle2", {7'b0, out_valid}, 8'h01);

    // directed vectors, back-to-back
    send(1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);   // -1
    send(1'b0, 4'h2, 1'b1, 8'h80, 1'b0, 1'b0, 8'h76, 1'b1);   // 48
    send(1'b0, 4'h0, 1'b0, 8'h08, 1'b0, 1'b0, 8'h40, 1'b1);   // tie, even lsb
    send(1'b0, 4'h0, 1'b0, 8'h18, 1'b0, 1'b0, EXP_18, 1'b1);  // tie, odd lsb
    send(1'b0, 4'hF, 1'b1, 8'h40, 1'b0, 1'b0, 8'h34, 1'b1);   // k=-1
    send(1'b0, 4'h7, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b1);   // saturate max
    send(1'b1, 4'h7, 1'b0, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1);   // -maxpos
    send(1'b0, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1);   // saturate min
    send(1'b0, 4'h9, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1);   // k=-7 rounds to 0 -> minpos
    send(1'b0, 4'h6, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1);   // k=6 top of range
    send(1'b0, 4'h5, 1'b1, 8'h80, 1'b0, 1'b0, EXP_OVF, 1'b1); // carry into regime
    send(1'b1, 4'h3, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1);   // zero ignores sign
    send(1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1);   // NaR beats zero
    idle();
    drain();

    // backpressure: three inputs while the output is stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1);
        send(1'b0, 4'h2, 1'b1, 8'h80, 1'b0, 1'b0, 8'h76, 1'b1);
        send(1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #3;
        chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
        chk("bp_out_posit", out_posit, 8'h40);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with two words in flight: neither may appear
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(1'b0, 4'h2, 1'b1, 8'h80, 1'b0, 1'b0, 8'h76, 1'b0);
    send(1'b0, 4'h7, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_mid_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_mid_in_ready", {7'b0, in_ready}, 8'h01);
    repeat (5) @(posedge clk);
    send(1'b0, 4'hF, 1'b1, 8'h40, 1'b0, 1'b0, 8'h34, 1'b1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
